// File: rtl/median_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// median_feeder: streams a stored frame as column triplets into median_filter and
// tags valid medians. Build macro MEDIAN_FEEDER_BORDER_EN adds edge replication. Rev 1.0
// ----------------------------------------------------------------------------
module median_feeder #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        o_data,
  output logic              o_en1,
  output logic              o_en2,
  output logic              med_valid,
  output logic [XW-1:0]     med_x,
  output logic [YW-1:0]     med_y
);
  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 1);
`ifdef MEDIAN_FEEDER_BORDER_EN
  localparam int COL_LAST  = IMG_W + 1;
  localparam int ROW_FIRST = 0;
  localparam int ROW_LAST  = IMG_H - 1;
  localparam int X_OFS     = 2;
`else
  localparam int COL_LAST  = IMG_W - 1;
  localparam int ROW_FIRST = 1;
  localparam int ROW_LAST  = IMG_H - 2;
  localparam int X_OFS     = 1;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]        r_state, w_next;
  logic [1:0]        r_ph;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              w_active, w_col_end, w_last_read;
  int                w_rr, w_cc;
  logic [ADDR_W-1:0] w_addr;
  logic              r_rd_d, r_en1, r_en2, r_done, r_mv;
  logic              r_ct_v, r_s0_v, r_s1_v;
  logic [XW-1:0]     r_ct_x, r_s0_x, r_s1_x, r_mx;
  logic [YW-1:0]     r_ct_y, r_s0_y, r_s1_y, r_my;

  assign w_col_end   = (r_ph == 2'd2);
  assign w_last_read = w_col_end && (r_col == CW'(COL_LAST)) && (r_row == RW'(ROW_LAST));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_STREAM;
      S_STREAM: if (w_last_read) w_next = S_FLUSH;
      S_FLUSH:  if (w_col_end && (r_col == CW'(1))) w_next = S_DRAIN;
      S_DRAIN:  if (r_mv) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    rd_en    = (r_state == S_STREAM);
    w_active = (r_state == S_STREAM) || (r_state == S_FLUSH);
    rd_addr  = rd_en ? w_addr : '0;
  end

  // Rows y-1..y+1 for the current phase; border build clamps both indices into the frame.
  always_comb begin
    w_rr = int'(r_row) + int'(r_ph) - 1;
    w_cc = int'(r_col);
`ifdef MEDIAN_FEEDER_BORDER_EN
    w_cc = w_cc - 1;
    if (w_rr < 0) w_rr = 0;
    else if (w_rr > IMG_H - 1) w_rr = IMG_H - 1;
    if (w_cc < 0) w_cc = 0;
    else if (w_cc > IMG_W - 1) w_cc = IMG_W - 1;
`endif
    w_addr = ADDR_W'(w_rr * IMG_W + w_cc);
  end

  // In FLUSH r_col is reused to count the two dummy columns.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE)) begin
      r_ph  <= 2'd0;
      r_col <= '0;
      r_row <= RW'(ROW_FIRST);
    end else if (w_col_end) begin
      r_ph <= 2'd0;
      if ((r_state == S_STREAM) && (r_col == CW'(COL_LAST))) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else begin
      r_ph <= r_ph + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_d <= 1'b0;
      r_en1  <= 1'b0;
      r_en2  <= 1'b0;
      r_done <= 1'b0;
      r_mv   <= 1'b0;
      r_ct_v <= 1'b0;
      r_ct_x <= '0;
      r_ct_y <= '0;
      r_s0_v <= 1'b0;
      r_s0_x <= '0;
      r_s0_y <= '0;
      r_s1_v <= 1'b0;
      r_s1_x <= '0;
      r_s1_y <= '0;
      r_mx   <= '0;
      r_my   <= '0;
    end else begin
      r_rd_d <= rd_en;
      r_en1  <= w_active && !w_col_end;
      r_en2  <= w_active && w_col_end;
      r_done <= (r_state == S_DRAIN) && r_mv;
      if (w_active && w_col_end) begin
        r_ct_v <= (r_state == S_STREAM) && (r_col >= CW'(2));
        r_ct_x <= XW'(r_col - CW'(X_OFS));
        r_ct_y <= YW'(r_row);
      end
      // Tag of column k leaves the pipe when column k+2 is captured by the filter.
      if (r_en2) begin
        r_s0_v <= r_ct_v;
        r_s0_x <= r_ct_x;
        r_s0_y <= r_ct_y;
        r_s1_v <= r_s0_v;
        r_s1_x <= r_s0_x;
        r_s1_y <= r_s0_y;
      end
      r_mv <= r_en2 && r_s1_v;
      if (r_en2 && r_s1_v) begin
        r_mx <= r_s1_x;
        r_my <= r_s1_y;
      end
    end
  end

  assign o_data    = r_rd_d ? rd_data : 8'd0;
  assign o_en1     = r_en1;
  assign o_en2     = r_en2;
  assign done      = r_done;
  assign med_valid = r_mv;
  assign med_x     = r_mx;
  assign med_y     = r_my;

endmodule
`default_nettype wire

// File: tb/tb_median_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_median_feeder: directed checks of median_feeder on 4x3 and 5x5 frames. Rev 1.0
// ----------------------------------------------------------------------------
module tb_median_feeder;
  localparam int AW = 4, AH = 3, BW = 5, BH = 5;
`ifdef MEDIAN_FEEDER_BORDER_EN
  localparam int BORDER = 1;
  localparam int CPS_A = AW + 2, KA = AH * (AW + 2), KB = BH * (BW + 2);
  localparam int XF = 0, YF = 0, XLA = AW - 1, XLB = BW - 1, YLB = BH - 1;
  localparam int NWA = AW * AH, NWB = BW * BH;
`else
  localparam int BORDER = 0;
  localparam int CPS_A = AW, KA = (AH - 2) * AW, KB = (BH - 2) * BW;
  localparam int XF = 1, YF = 1, XLA = AW - 2, XLB = BW - 2, YLB = BH - 2;
  localparam int NWA = (AW - 2) * (AH - 2), NWB = (BW - 2) * (BH - 2);
`endif
  localparam int DONE_A = 3 * KA + 8;
  localparam int DONE_B = 3 * KB + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, rden_a, en1_a, en2_a, mv_a;
  logic busy_b, done_b, rden_b, en1_b, en2_b, mv_b;
  logic [7:0] addr_a, addr_b, rdata_a, rdata_b, odata_a, odata_b;
  logic [1:0] mx_a, my_a;
  logic [2:0] mx_b, my_b;
  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:255];

  int total = 0;
  int bad = 0;
  int sa [0:255];
  int sb [0:255];
  int nsa, nsb, mva, mvb, exa, eya, exb, eyb;
  bit mon_a = 0, mon_b = 0;

  always #5 clk = ~clk;

  median_feeder #(.IMG_W(AW), .IMG_H(AH), .ADDR_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rden_a), .rd_addr(addr_a), .rd_data(rdata_a), .o_data(odata_a),
    .o_en1(en1_a), .o_en2(en2_a), .med_valid(mv_a), .med_x(mx_a), .med_y(my_a));

  median_feeder #(.IMG_W(BW), .IMG_H(BH), .ADDR_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rden_b), .rd_addr(addr_b), .rd_data(rdata_b), .o_data(odata_b),
    .o_en1(en1_b), .o_en2(en2_b), .med_valid(mv_b), .med_x(mx_b), .med_y(my_b));

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = (BORDER != 0) ? 8'd7 : 8'(i);
      mem_b[i] = 8'd20;
    end
    mem_b[2 * BW + 2] = 8'd255;
  end

  always @(posedge clk) begin
    if (rden_a) rdata_a <= mem_a[addr_a];
    if (rden_b) rdata_b <= mem_b[addr_b];
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int med9(input int v[9]);
    int a[9];
    int t;
    a = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  // med_valid for frame A: column k's window reports at C0+3k+7 when its tag is valid.
  function automatic int exp_mv(input int t);
    int k;
    if (t < 10 || ((t - 7) % 3) != 0) return 0;
    k = (t - 7) / 3;
    if (k > KA) return 0;
    return (((k - 1) % CPS_A) >= 2) ? 1 : 0;
  endfunction

  // Filter stand-in: records every strobed sample; a window is the 9 samples of columns n-5..n-3.
  always @(posedge clk) begin
    if ((en1_a || en2_a) && nsa < 256) begin sa[nsa] = int'(odata_a); nsa++; end
    if ((en1_b || en2_b) && nsb < 256) begin sb[nsb] = int'(odata_b); nsb++; end
  end

  always @(negedge clk) begin : m_a
    int w[9];
    int n;
    if (mon_a && mv_a) begin
      n = nsa / 3;
      for (int i = 0; i < 9; i++) w[i] = (3 * (n - 5) + i >= 0) ? sa[3 * (n - 5) + i] : -1;
      chk("medA_x", int'(mx_a), exa);
      chk("medA_y", int'(my_a), eya);
      chk("medA_val", med9(w), (BORDER != 0) ? 7 : eya * AW + exa);
      mva++;
      exa++;
      if (exa > XLA) begin exa = XF; eya++; end
    end
  end

  always @(negedge clk) begin : m_b
    int w[9];
    int n;
    if (mon_b && mv_b) begin
      n = nsb / 3;
      for (int i = 0; i < 9; i++) w[i] = (3 * (n - 5) + i >= 0) ? sb[3 * (n - 5) + i] : -1;
      chk("medB_x", int'(mx_b), exb);
      chk("medB_y", int'(my_b), eyb);
      chk("medB_val", med9(w), 20);
      mvb++;
      exb++;
      if (exb > XLB) begin exb = XF; eyb++; end
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_rden"}, int'(rden_a), 0);
    chk({tag, "_addr"}, int'(addr_a), 0);
    chk({tag, "_data"}, int'(odata_a), 0);
    chk({tag, "_en1"}, int'(en1_a), 0);
    chk({tag, "_en2"}, int'(en2_a), 0);
    chk({tag, "_mv"}, int'(mv_a), 0);
    chk({tag, "_mx"}, int'(mx_a), 0);
    chk({tag, "_my"}, int'(my_a), 0);
  endtask

  // mode 0: full frame; mode 1: extra start at C0+5, reset at C0+10.
  task automatic frame_a(input int mode);
    int at[9];
`ifdef MEDIAN_FEEDER_BORDER_EN
    at = '{0, 0, 4, 0, 0, 4, 1, 1, 5};
`else
    at = '{0, 4, 8, 1, 5, 9, 2, 6, 10};
`endif
    nsa = 0; mva = 0; exa = XF; eya = YF; mon_a = 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int t = 0; t <= DONE_A + 2; t++) begin
      if (mode == 1 && t == 11) begin
        chk_reset_a("midrst");
        rst = 1'b0;
        break;
      end
      chk("busyA", int'(busy_a), (t < DONE_A) ? 1 : 0);
      chk("doneA", int'(done_a), (t == DONE_A) ? 1 : 0);
      chk("rdenA", int'(rden_a), (t < 3 * KA) ? 1 : 0);
      chk("en1A", int'(en1_a), (t >= 1 && t <= 3 * KA + 6 && ((t - 1) % 3) != 2) ? 1 : 0);
      chk("en2A", int'(en2_a), (t >= 1 && t <= 3 * KA + 6 && ((t - 1) % 3) == 2) ? 1 : 0);
      chk("mvA", int'(mv_a), exp_mv(t));
      if (t < 9) chk("addrA", int'(addr_a), at[t]);
      if (t >= 1 && t <= 9) chk("dataA", int'(odata_a), (BORDER != 0) ? 7 : at[t-1]);
      if (t > 3 * KA) chk("dataA_flush", int'(odata_a), 0);
      if (mode == 1 && t == 5) start_a = 1'b1;
      if (mode == 1 && t == 10) rst = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    if (mode == 0) begin
      chk("nwinA", mva, NWA);
      chk("endA_y", eya, (BORDER != 0) ? AH : AH - 1);
    end
    mon_a = 0;
    @(negedge clk);
  endtask

  initial begin
    int t;
    nsa = 0; nsb = 0;
    repeat (3) @(negedge clk);
    chk_reset_a("rst");
    chk("rst_busyB", int'(busy_b), 0);
    chk("rst_mvB", int'(mv_b), 0);
    rst = 1'b0;
    @(negedge clk);
    frame_a(0);
    frame_a(1);
    @(negedge clk);
    frame_a(0);

    nsb = 0; mvb = 0; exb = XF; eyb = YF; mon_b = 1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    t = 0;
    while (!done_b && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("doneB_cycle", t, DONE_B);
    chk("busyB_at_done", int'(busy_b), 0);
    chk("nwinB", mvb, NWB);
    chk("endB_y", eyb, YLB + 1);
    mon_b = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
